// File: rtl/multicycle_datapath_ctrl.sv
// multicycle_datapath_ctrl
//   Multicycle RV32I-subset core: lw, sw, R-type add/sub/and/or/slt,
//   addi/andi/ori/slti, beq and jal. Instruction fetch and data access
//   share one memory port, and every memory state waits for MemReady.
//   An unknown opcode parks the core in HALT until reset. A counter
//   tracks retired instructions.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   MemReq/MemWE         access request (held until MemReady), write enable
//   MemAddr/MemWData     byte address (PC or ALUOut), store data (B)
//   MemRData/MemReady    read data, access completion in the same cycle
//   PC                   architectural PC
//   Halted               core stopped on an illegal instruction
//   InstrRetired         count of completed instructions (wraps)
//   dbg_state            current main FSM state encoding
// Handshake: an access completes in a cycle where MemReq and MemReady are
//   both 1. MemAddr, MemWE and MemWData hold steady from the first request
//   cycle through that completion cycle.
module multicycle_datapath_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             MemReq,
   output logic             MemWE,
   output logic [XLEN-1:0]  MemAddr,
   output logic [XLEN-1:0]  MemWData,
   input  logic [XLEN-1:0]  MemRData,
   input  logic             MemReady,
   output logic [XLEN-1:0]  PC,
   output logic             Halted,
   output logic [CNT_W-1:0] InstrRetired,
   output logic [3:0]       dbg_state
);
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JALEX, JAL, HALT
   } state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d, old_pc_q, old_pc_d;
   logic [XLEN-1:0]  data_q, data_d, a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]  alu_out_q, alu_out_d;
   logic [31:0]      instr_q, instr_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [XLEN-1:0]  rf_q [0:31];

   logic            rf_we, retire, mem_req, mem_we, beq_zero;
   logic [XLEN-1:0] rf_wd, mem_addr, rs1_val, rs2_val, beq_diff;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic [2:0]      funct3;

   assign opcode = instr_q[6:0];
   assign rd     = instr_q[11:7];
   assign funct3 = instr_q[14:12];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];

   assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
   assign imm_s = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                   instr_q[30:25], instr_q[11:8], 1'b0};
   assign imm_j = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                   instr_q[20], instr_q[30:21], 1'b0};

   // x0 reads as zero regardless of array contents
   assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

   function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y,
                                             input logic [2:0]      f3,
                                             input logic            sub);
      case (f3)
         3'b000:  alu_f = sub ? (x - y) : (x + y);
         3'b010:  alu_f = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
         3'b110:  alu_f = x | y;
         3'b111:  alu_f = x & y;
         default: alu_f = x + y;
      endcase
   endfunction

   assign beq_diff = alu_f(a_q, b_q, 3'b000, 1'b1);
   assign beq_zero = (beq_diff == '0);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      old_pc_d  = old_pc_q;
      instr_d   = instr_q;
      data_d    = data_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      rf_we     = 1'b0;
      rf_wd     = '0;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (MemReady) begin
               instr_d  = MemRData[31:0];
               old_pc_d = pc_q;
               pc_d     = pc_q + XLEN'(4);
               state_d  = DECODE;
            end
         end
         DECODE: begin
            a_d       = rs1_val;
            b_d       = rs2_val;
            alu_out_d = old_pc_q + imm_b;  // branch target, used only by BEQ
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTER;
               OP_I:         state_d = EXECUTEI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JALEX;
               default:      state_d = HALT;
            endcase
         end
         MEMADR: begin
            alu_out_d = a_q + ((opcode == OP_SW) ? imm_s : imm_i);
            state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mem_req  = 1'b1;
            mem_addr = alu_out_q;
            if (MemReady) begin
               data_d  = MemRData;
               state_d = MEMWB;
            end
         end
         MEMWB: begin
            rf_we   = 1'b1;
            rf_wd   = data_q;
            retire  = 1'b1;
            state_d = FETCH;
         end
         MEMWRITE: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = alu_out_q;
            if (MemReady) begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         EXECUTER: begin
            alu_out_d = alu_f(a_q, b_q, funct3, instr_q[30]);
            state_d   = ALUWB;
         end
         EXECUTEI: begin
            alu_out_d = alu_f(a_q, imm_i, funct3, 1'b0);
            state_d   = ALUWB;
         end
         ALUWB: begin
            rf_we   = 1'b1;
            rf_wd   = alu_out_q;
            retire  = 1'b1;
            state_d = FETCH;
         end
         BEQ: begin
            if (beq_zero) pc_d = alu_out_q;
            retire  = 1'b1;
            state_d = FETCH;
         end
         // jal spends one cycle forming the target in ALUOut, then links
         JALEX: begin
            alu_out_d = old_pc_q + imm_j;
            state_d   = JAL;
         end
         JAL: begin
            rf_we   = 1'b1;
            rf_wd   = old_pc_q + XLEN'(4);
            pc_d    = alu_out_q;
            retire  = 1'b1;
            state_d = FETCH;
         end
         HALT: state_d = HALT;
         default: state_d = HALT;
      endcase
      retired_d = retired_q + CNT_W'(retire);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         old_pc_q  <= '0;
         instr_q   <= '0;
         data_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         old_pc_q  <= old_pc_d;
         instr_q   <= instr_d;
         data_q    <= data_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         retired_q <= retired_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rf_we && (rd != 5'd0)) begin
         rf_q[rd] <= rf_wd;
      end
   end

   // Requests are suppressed combinationally so reset kills an access at once
   assign MemReq       = mem_req & ~reset;
   assign MemWE        = mem_we & ~reset;
   assign MemAddr      = mem_addr;
   assign MemWData     = b_q;
   assign PC           = pc_q;
   assign Halted       = (state_q == HALT);
   assign InstrRetired = retired_q;
   assign dbg_state    = state_q;
endmodule

// File: tb/tb_multicycle_datapath_ctrl.sv
module tb_multicycle_datapath_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] ILL    = 32'h0000_007F;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReq, MemWE, Halted;
  logic        MemReady = 1'b0;
  logic [31:0] MemAddr, MemWData, PC, InstrRetired;
  logic [31:0] MemRData = 32'h0;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  multicycle_datapath_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWE(MemWE),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
    .MemReady(MemReady), .PC(PC), .Halted(Halted),
    .InstrRetired(InstrRetired), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // ---------------- memory responder ----------------
  logic [31:0] mem [0:1023];
  int          stall_mode = 0;   // <0: random 0..2 on every access; else fixed wait on data accesses
  int          want_wait, wait_cnt, stall_total = 0, addr_err = 0, write_cnt = 0;
  bit          in_req = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  always @(negedge clk) begin
    if (reset || !MemReq) begin
      MemReady = 1'b0;
      in_req = 0;
    end else begin
      if (!in_req) begin
        in_req = 1;
        hold_addr = MemAddr; hold_we = MemWE; hold_wdata = MemWData;
        wait_cnt = 0;
        if (stall_mode < 0) want_wait = $urandom_range(0, 2);
        else if (MemAddr === PC) want_wait = 0;
        else want_wait = stall_mode;
      end else if (MemAddr !== hold_addr || MemWE !== hold_we ||
                   (hold_we && MemWData !== hold_wdata)) begin
        addr_err++;
      end
      if (wait_cnt < want_wait) begin
        MemReady = 1'b0;
        wait_cnt++;
      end else begin
        MemReady = 1'b1;
        MemRData = mem[MemAddr[11:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && MemReq === 1'b1) begin
      if (!MemReady) stall_total++;
      else begin
        if (MemWE) begin
          mem[MemAddr[11:2]] = MemWData;
          write_cnt++;
        end
        in_req = 0;
      end
    end
  end

  // ---------------- reference model (ISA level) ----------------
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc, m_retired;
  int          cyc_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic sub,
                                          input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x; sy = y;
    case (f3)
      3'b000:  return sub ? x - y : x + y;
      3'b010:  return (sx < sy) ? 32'd1 : 32'd0;
      3'b110:  return x | y;
      3'b111:  return x & y;
      default: return x + y;
    endcase
  endfunction

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  // Executes one instruction on the model; base = zero-wait cycle count
  task automatic model_step(output bit ill, output int base);
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, ea, npc;
    ins   = m_mem[m_pc[11:2]];
    a     = m_regs[ins[19:15]];
    b     = m_regs[ins[24:20]];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc   = m_pc + 32'd4;
    ill   = 0;
    base  = 0;
    case (ins[6:0])
      7'b0010011: begin base = 4; set_reg(ins[11:7], ref_alu(ins[14:12], 1'b0, a, imm_i)); end
      7'b0110011: begin base = 4; set_reg(ins[11:7], ref_alu(ins[14:12], ins[30], a, b)); end
      7'b0000011: begin base = 5; ea = a + imm_i; set_reg(ins[11:7], m_mem[ea[11:2]]); end
      7'b0100011: begin base = 4; ea = a + imm_s; m_mem[ea[11:2]] = b; end
      7'b1100011: begin base = 3; if (a == b) npc = m_pc + imm_b; end
      7'b1101111: begin base = 4; set_reg(ins[11:7], m_pc + 32'd4); npc = m_pc + imm_j; end
      default:    begin ill = 1; base = 2; end
    endcase
    m_pc = npc;
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_r(input logic sub, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {1'b0, sub, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'h0; m_mem[i] = 32'h0; end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
    m_mem[addr[11:2]] = w;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Resets the core, then steps model and DUT instruction by instruction
  task automatic run_program(input int mode, input int max_instr);
    bit ill;
    int base, cyc, st0, n, hi_cnt;
    stall_mode = mode;
    addr_err = 0;
    apply_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc = RST_PC;
    m_retired = 32'h0;
    cyc_q.delete();
    n = 0;
    forever begin
      st0 = stall_total;
      cyc = 0;
      model_step(ill, base);
      if (ill) begin
        while (Halted !== 1'b1 && cyc < 60) begin @(posedge clk); cyc++; @(negedge clk); end
        total++;
        if (Halted !== 1'b1 || cyc != base + (stall_total - st0)) begin
          bad++; $display("FAIL halt_timing: halted=%b after %0d cycles, want 1 after %0d", Halted, cyc, base + (stall_total - st0));
        end
        total++;
        if (PC !== m_pc) begin bad++; $display("FAIL halt_pc: got %h want %h", PC, m_pc); end
        hi_cnt = 0;
        repeat (3) begin @(negedge clk); if (MemReq !== 1'b0) hi_cnt++; end
        total++;
        if (hi_cnt != 0 || InstrRetired !== m_retired || Halted !== 1'b1) begin
          bad++; $display("FAIL halt_idle: memreq_cycles=%0d retired=%0d halted=%b want 0 %0d 1", hi_cnt, InstrRetired, Halted, m_retired);
        end
        break;
      end
      while (InstrRetired === m_retired && cyc < 60) begin @(posedge clk); cyc++; @(negedge clk); end
      m_retired = m_retired + 32'd1;
      cyc_q.push_back(cyc);
      total++;
      if (InstrRetired !== m_retired) begin bad++; $display("FAIL retire_count: got %0d want %0d", InstrRetired, m_retired); end
      total++;
      if (cyc != base + (stall_total - st0)) begin bad++; $display("FAIL cycles: instr %0d took %0d want %0d", n, cyc, base + (stall_total - st0)); end
      total++;
      if (PC !== m_pc) begin bad++; $display("FAIL pc: instr %0d got %h want %h", n, PC, m_pc); end
      n++;
      if (n >= max_instr) begin total++; bad++; $display("FAIL runaway: %0d instructions without halt", n); break; end
    end
    total++;
    if (addr_err != 0) begin bad++; $display("FAIL req_stable: %0d unstable cycles want 0", addr_err); end
    // scoreboard: low words and the data region against the model image
    for (int i = 0; i < 16; i++) exp_q.push_back(m_mem[i]);
    for (int i = 'h180; i < 'h200; i++) exp_q.push_back(m_mem[i]);
    for (int i = 0; i < 16 + 128; i++) begin
      logic [31:0] e;
      int idx;
      idx = (i < 16) ? i : ('h180 + i - 16);
      e = exp_q.pop_front();
      total++;
      if (mem[idx] !== e) begin bad++; $display("FAIL mem_word[%0h]: got %h want %h", idx * 4, mem[idx], e); end
    end
  endtask

  // ---------------- tests ----------------
  task automatic load_alu_prog();
    clear_mem();
    put(32'h100, enc_i(3'b000, 5'd1, 5'd0, 32'd5));
    put(32'h104, enc_i(3'b000, 5'd2, 5'd0, 32'hFFFF_FFFD));
    put(32'h108, enc_r(1'b0, 3'b000, 5'd3, 5'd1, 5'd2));
    put(32'h10C, enc_r(1'b1, 3'b000, 5'd4, 5'd2, 5'd1));
    put(32'h110, enc_r(1'b0, 3'b010, 5'd5, 5'd2, 5'd1));
    put(32'h114, enc_sw(5'd3, 5'd0, 32'h600));
    put(32'h118, enc_sw(5'd4, 5'd0, 32'h604));
    put(32'h11C, enc_sw(5'd5, 5'd0, 32'h608));
    put(32'h120, ILL);
  endtask

  task automatic test_reset();
    load_alu_prog();
    stall_mode = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (MemReq !== 1'b0 || MemWE !== 1'b0) begin bad++; $display("FAIL reset_req: req=%b we=%b want 0 0", MemReq, MemWE); end
    total++;
    if (PC !== RST_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", PC, RST_PC); end
    total++;
    if (InstrRetired !== 32'd0 || Halted !== 1'b0) begin bad++; $display("FAIL reset_cnt: retired=%0d halted=%b want 0 0", InstrRetired, Halted); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (MemReq !== 1'b1 || MemAddr !== RST_PC) begin bad++; $display("FAIL first_fetch: req=%b addr=%h want 1 %h", MemReq, MemAddr, RST_PC); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (PC !== RST_PC + 32'd4 || InstrRetired !== 32'd0) begin
      bad++; $display("FAIL after_fetch: pc=%h retired=%0d want %h 0", PC, InstrRetired, RST_PC + 32'd4);
    end
  endtask

  task automatic test_alu();
    int sum;
    load_alu_prog();
    run_program(0, 50);
    sum = 0;
    for (int i = 0; i < 5 && i < cyc_q.size(); i++) sum += cyc_q[i];
    total++;
    if (sum != 20) begin bad++; $display("FAIL alu_cycles: got %0d want 20", sum); end
    total++;
    if (mem['h180] !== 32'd2 || mem['h181] !== 32'hFFFF_FFF8 || mem['h182] !== 32'd1) begin
      bad++; $display("FAIL alu_results: got %h %h %h want 2 fffffff8 1", mem['h180], mem['h181], mem['h182]);
    end
  endtask

  task automatic test_mem_stall();
    clear_mem();
    put(32'h100, enc_i(3'b000, 5'd1, 5'd0, 32'd5));
    put(32'h104, enc_sw(5'd1, 5'd0, 32'd8));
    put(32'h108, enc_lw(5'd6, 5'd0, 32'd8));
    put(32'h10C, enc_sw(5'd6, 5'd0, 32'h610));
    put(32'h110, ILL);
    run_program(2, 50);
    total++;
    if (mem[2] !== 32'd5 || mem['h184] !== 32'd5) begin bad++; $display("FAIL ldst_data: mem8=%h x6=%h want 5 5", mem[2], mem['h184]); end
    total++;
    if (cyc_q.size() < 3 || cyc_q[1] != 6 || cyc_q[2] != 7) begin bad++; $display("FAIL ldst_cycles: sw/lw cycles wrong, want 6 and 7"); end
  endtask

  task automatic test_branch();
    clear_mem();
    put(32'h100, enc_i(3'b000, 5'd1, 5'd0, 32'd5));
    put(32'h104, enc_i(3'b000, 5'd2, 5'd0, 32'hFFFF_FFFD));
    put(32'h108, enc_jal(5'd0, 32'd12));
    put(32'h10C, enc_beq(5'd1, 5'd2, 32'd8));
    put(32'h110, ILL);
    put(32'h114, enc_beq(5'd1, 5'd1, 32'hFFFF_FFF8));
    run_program(0, 50);
    total++;
    if (cyc_q.size() != 5 || cyc_q[3] != 3 || cyc_q[4] != 3) begin bad++; $display("FAIL beq_cycles: %0d instrs, want 5 with beq at 3 cycles", cyc_q.size()); end
  endtask

  task automatic test_jal();
    clear_mem();
    put(32'h100, enc_jal(5'd0, 32'hFFFF_FF20));
    put(32'h020, enc_jal(5'd1, 32'd16));
    put(32'h030, enc_i(3'b000, 5'd0, 5'd0, 32'd7));
    put(32'h034, enc_sw(5'd1, 5'd0, 32'h600));
    put(32'h038, enc_sw(5'd0, 5'd0, 32'h604));
    put(32'h03C, ILL);
    put(32'h604, 32'h5A5A_5A5A);
    run_program(0, 50);
    total++;
    if (mem['h180] !== 32'h24 || mem['h181] !== 32'h0) begin bad++; $display("FAIL jal_link: x1=%h x0=%h want 24 0", mem['h180], mem['h181]); end
    total++;
    if (cyc_q.size() < 2 || cyc_q[1] != 4) begin bad++; $display("FAIL jal_cycles: want 4"); end
  endtask

  task automatic test_reset_mid_write();
    int cyc, w0;
    clear_mem();
    put(32'h100, enc_i(3'b000, 5'd1, 5'd0, 32'd5));
    put(32'h104, enc_sw(5'd1, 5'd0, 32'h600));
    put(32'h108, ILL);
    put(32'h600, 32'hDEAD_BEEF);
    stall_mode = 6;
    apply_reset();
    cyc = 0;
    while (!(MemReq === 1'b1 && MemWE === 1'b1) && cyc < 40) begin @(posedge clk); @(negedge clk); cyc++; end
    total++;
    if (MemWE !== 1'b1) begin bad++; $display("FAIL mw_reach: write request not seen in %0d cycles", cyc); end
    @(posedge clk);
    @(negedge clk);
    w0 = write_cnt;
    #1 reset = 1'b1;
    #1;
    total++;
    if (MemWE !== 1'b0 || MemReq !== 1'b0) begin bad++; $display("FAIL mw_drop: we=%b req=%b want 0 0", MemWE, MemReq); end
    repeat (2) @(posedge clk);
    total++;
    if (write_cnt != w0 || mem['h180] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mw_nowrite: mem=%h writes=%0d want deadbeef 0", mem['h180], write_cnt - w0); end
    stall_mode = 0;
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (MemReq !== 1'b1 || MemAddr !== RST_PC || PC !== RST_PC || InstrRetired !== 32'd0) begin
      bad++; $display("FAIL mw_restart: req=%b addr=%h pc=%h ret=%0d want 1 %h %h 0", MemReq, MemAddr, PC, InstrRetired, RST_PC, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3s [4];
    logic [31:0] a, w;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;
    for (int it = 0; it < 4; it++) begin
      clear_mem();
      for (int k = 'h180; k < 'h1C0; k++) begin
        w = $urandom;
        a = k * 4;
        put(a, w);
      end
      a = RST_PC;
      for (int k = 0; k < 24; k++) begin
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = f3s[$urandom_range(0, 3)];
        case ($urandom_range(0, 9))
          0, 1, 2: w = enc_i(f3, rd, rs1, 32'($urandom_range(0, 4095)));
          3, 4:    w = enc_r((f3 == 3'b000) ? 1'($urandom_range(0, 1)) : 1'b0, f3, rd, rs1, rs2);
          5:       w = enc_lw(rd, 5'd0, 32'h600 + 32'($urandom_range(0, 63)) * 4);
          6:       w = enc_sw(rs2, 5'd0, 32'h600 + 32'($urandom_range(0, 63)) * 4);
          7:       w = enc_beq(rs1, rs2, ($urandom_range(0, 1) != 0) ? 32'd8 : 32'd12);
          8:       w = enc_jal(rd, 32'd8);
          default: w = enc_i(3'b000, rd, 5'd0, 32'($urandom_range(0, 4095)));
        endcase
        put(a, w);
        a = a + 32'd4;
      end
      for (int k = 1; k < 8; k++) begin
        put(a, enc_sw(5'(k), 5'd0, 32'h700 + 32'(k) * 4));
        a = a + 32'd4;
      end
      put(a, ILL);
      run_program(-1, 100);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    clear_mem();
    test_reset();
    test_alu();
    test_mem_stall();
    test_branch();
    test_jal();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath_ctrl.md
Name: multicycle_datapath_ctrl

Overview:
- Parametrised multicycle RV32I-subset core: shared-memory datapath plus internal main FSM.
- Successor to the single-cycle datapath. Uses one unified memory port with a ready handshake instead of separate instruction and data ports.
- Generalised in data width, reset vector and wait-state tolerance. Adds an illegal-instruction halt and a retired-instruction counter.
- Sits between the memory/bus model and the top-level testbench.

Parameters:
- XLEN, 32, register/ALU/address width; legal values 32 or 64. Immediates are sign-extended to XLEN.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- MemReq  out  1  memory access request; held until MemReady
- MemWE  out  1  write enable, qualified by MemReq
- MemAddr  out  XLEN  byte address (PC in fetch, ALUOut in data phase)
- MemWData  out  XLEN  store data (B register)
- MemRData  in  XLEN  read data; valid in the cycle MemReady=1
- MemReady  in  1  access completes in the cycle MemReq&MemReady
- PC  out  XLEN  architectural PC
- Halted  out  1  core stopped on an illegal instruction
- InstrRetired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async): PC=RESET_PC, state=FETCH, all internal registers=0, regfile x1..x31=0, InstrRetired=0, Halted=0.
  - MemReq, MemWE forced 0 while reset=1.
  - Reset mid-access abandons the access with no register or memory side effect.
- Internal registers, all written only on enabled cycles: OldPC, Instr, Data, A, B, ALUOut.
- Regfile:
  - Reads are asynchronous.
  - Writes occur on the clock edge.
  - x0 always reads 0; writes to x0 are ignored.
- ALU ops:
  - add, sub, and, or, slt (signed XLEN compare).
  - Zero = (result==0).
  - Wrap-around is modulo 2^XLEN with no overflow flag.
- Decode:
  - op 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU (addi/andi/ori/slti), 1100011 beq, 1101111 jal.
  - R-type: funct7[5]=1 with funct3=000 selects sub.
- FSM states and transitions (MemReady stalls every memory state):
  - FETCH: MemReq=1, MemAddr=PC. On MemReady: Instr<=MemRData, OldPC<=PC, PC<=PC+4 -> DECODE.
  - DECODE: A<=rs1, B<=rs2, ALUOut<=OldPC+immB. Opcode dispatch below; unknown opcode -> HALT.
  - MEMADR: ALUOut<=A+imm(I or S). lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: MemReq=1, MemAddr=ALUOut. On MemReady: Data<=MemRData -> MEMWB.
  - MEMWB: rd<=Data, retire -> FETCH.
  - MEMWRITE: MemReq=1, MemWE=1. On MemReady: retire -> FETCH.
  - EXECUTER / EXECUTEI: ALUOut<=A op B (R) or A op immI (I) -> ALUWB.
  - ALUWB: rd<=ALUOut, retire -> FETCH.
  - BEQ: compute A-B. If Zero, PC<=ALUOut. Retire -> FETCH.
  - JAL: rd<=OldPC+4, PC<=OldPC+immJ, retire -> FETCH.
  - HALT: terminal until reset. Halted=1, MemReq=0, PC frozen at OldPC+4, no retire.
- Cycle counts with zero wait states: beq 3, R/I/sw/jal 4, lw 5. Each MemReady-low cycle adds 1.
- Memory handshake: MemAddr, MemWE and MemWData are stable from request to completion.
- Retire:
  - InstrRetired increments by 1 on the final-state cycle of each instruction.
  - The counter wraps at 2^CNT_W.
- Misaligned load/store addresses are passed through unchecked; PC always stays 4-aligned.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory -> the first MemReq cycle has MemAddr=0x100; PC=0x104 after the fetch; InstrRetired=0.
- addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1; slt x5,x2,x1 -> x3=2, x4=-8, x5=1; InstrRetired=5; 20 cycles total.
- sw x1,8(x0) then lw x6,8(x0), with MemReady low for 2 cycles on each access -> memory[8]=5, x6=5, lw takes 7 cycles, address stable throughout the stall.
- beq x1,x1,-8 taken and beq x1,x2,+8 not taken -> PC=OldPC-8 and PC=OldPC+4 respectively; each takes 3 cycles.
- jal x1,+16 at PC 0x20 -> x1=0x24, PC=0x30; addi x0,x0,7 -> x0 reads 0.
- Opcode 0x0000007F -> Halted=1 two cycles after fetch, MemReq stays 0; reset asserted mid-MEMWRITE stall -> MemWE drops immediately, no write occurs, restart at RESET_PC.
